issue_tracker: RTL

// - Parametrised in-flight instruction tracker between decode and the execute/commit stages.
// - Allocates one transaction ID per issued instruction into a circular buffer.
// - Collects results from NR_WB_PORTS writeback ports.
// - Answers operand-hazard lookups and presents up to NR_COMMIT_PORTS in-order completed entries to commit.

---
 rtl/issue_tracker.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/issue_tracker.sv
// issue_tracker: circular in-flight instruction tracker with writeback collection, an in-order
// commit window and operand hazard lookup. Define ISSUE_TRACKER_FWD_EN to forward completed results.
module issue_tracker #(
    parameter int unsigned NR_ENTRIES      = 8,
    parameter int unsigned NR_WB_PORTS     = 4,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned REG_ADDR_W      = 5,
    parameter int unsigned DATA_W          = 64,
    localparam int unsigned TID_W          = $clog2(NR_ENTRIES)
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic                                            flush_i,
    input  logic                                            issue_valid_i,
    output logic                                            issue_ready_o,
    input  logic [REG_ADDR_W-1:0]                           issue_rd_i,
    input  logic                                            issue_fpr_i,
    output logic [TID_W-1:0]                                issue_trans_id_o,
    input  logic [1:0][REG_ADDR_W-1:0]                      rs_addr_i,
    input  logic [1:0]                                      rs_fpr_i,
    output logic [1:0]                                      rs_busy_o,
    output logic [1:0]                                      rs_fwd_valid_o,
    output logic [1:0][DATA_W-1:0]                          rs_fwd_data_o,
    input  logic [NR_WB_PORTS-1:0]                          wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TID_W-1:0]               wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][DATA_W-1:0]              wb_data_i,
    input  logic [NR_WB_PORTS-1:0]                          wb_ex_i,
    output logic [NR_COMMIT_PORTS-1:0]                      commit_valid_o,
    output logic [NR_COMMIT_PORTS-1:0][TID_W-1:0]           commit_trans_id_o,
    output logic [NR_COMMIT_PORTS-1:0][REG_ADDR_W-1:0]      commit_rd_o,
    output logic [NR_COMMIT_PORTS-1:0]                      commit_fpr_o,
    output logic [NR_COMMIT_PORTS-1:0][DATA_W-1:0]          commit_data_o,
    output logic [NR_COMMIT_PORTS-1:0]                      commit_ex_o,
    input  logic [NR_COMMIT_PORTS-1:0]                      commit_ack_i,
    output logic [TID_W:0]                                  count_o
);

    logic [NR_ENTRIES-1:0] valid_q, valid_d, done_q, done_d, fpr_q, fpr_d, ex_q, ex_d;
    logic [REG_ADDR_W-1:0] rd_q   [NR_ENTRIES];
    logic [REG_ADDR_W-1:0] rd_d   [NR_ENTRIES];
    logic [DATA_W-1:0]     data_q [NR_ENTRIES];
    logic [DATA_W-1:0]     data_d [NR_ENTRIES];
    logic [TID_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [TID_W:0]        count_q, count_d;

    logic                       issue_hs_s;
    logic [NR_COMMIT_PORTS-1:0] cvalid_s, ack_s;
    logic [TID_W-1:0]           cidx_s [NR_COMMIT_PORTS];
    logic [TID_W:0]             n_ack_s;
    logic                       cv_run_s, ack_run_s, wb_take_s;
    logic [1:0]                 lk_hit_s;
    logic [TID_W-1:0]           lk_idx_s;
`ifdef ISSUE_TRACKER_FWD_EN
    logic [1:0]                 lk_done_s;
    logic [DATA_W-1:0]          lk_data_s [2];
`endif

    // Ready depends only on registered occupancy, never on this cycle's acks.
    assign issue_ready_o    = (count_q != (TID_W+1)'(NR_ENTRIES));
    assign issue_hs_s       = issue_valid_i & issue_ready_o;
    assign issue_trans_id_o = tail_q;
    assign count_o          = count_q;
    assign commit_valid_o   = cvalid_s;

    // In-order commit window: valid ports and acks are both prefixes from head.
    always_comb begin
        cvalid_s  = '0;
        ack_s     = '0;
        n_ack_s   = '0;
        cv_run_s  = 1'b1;
        ack_run_s = 1'b1;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            cidx_s[i]   = head_q + TID_W'(i);
            cvalid_s[i] = cv_run_s & valid_q[cidx_s[i]] & done_q[cidx_s[i]];
            cv_run_s    = cvalid_s[i];
            ack_s[i]    = ack_run_s & cvalid_s[i] & commit_ack_i[i];
            ack_run_s   = ack_s[i];
            n_ack_s     = n_ack_s + (TID_W+1)'(ack_s[i]);
        end
    end

    // Commit payload, zeroed on ports that are not presenting an entry.
    always_comb begin
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            commit_trans_id_o[i] = cvalid_s[i] ? cidx_s[i]         : '0;
            commit_rd_o[i]       = cvalid_s[i] ? rd_q[cidx_s[i]]   : '0;
            commit_fpr_o[i]      = cvalid_s[i] ? fpr_q[cidx_s[i]]  : 1'b0;
            commit_data_o[i]     = cvalid_s[i] ? data_q[cidx_s[i]] : '0;
            commit_ex_o[i]       = cvalid_s[i] ? ex_q[cidx_s[i]]   : 1'b0;
        end
    end

    // Operand lookup: walk oldest to youngest so the youngest match overrides.
    always_comb begin
        lk_hit_s = '0;
        lk_idx_s = '0;
`ifdef ISSUE_TRACKER_FWD_EN
        lk_done_s    = '0;
        lk_data_s[0] = '0;
        lk_data_s[1] = '0;
`endif
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                lk_idx_s = head_q + TID_W'(i);
                if (valid_q[lk_idx_s] && (rd_q[lk_idx_s] == rs_addr_i[j]) &&
                    (fpr_q[lk_idx_s] == rs_fpr_i[j]) && (rs_fpr_i[j] || (rs_addr_i[j] != '0))) begin
                    lk_hit_s[j]  = 1'b1;
`ifdef ISSUE_TRACKER_FWD_EN
                    lk_done_s[j] = done_q[lk_idx_s];
                    lk_data_s[j] = data_q[lk_idx_s];
`endif
                end else begin
                    lk_hit_s[j]  = lk_hit_s[j];
                end
            end
        end
    end

`ifdef ISSUE_TRACKER_FWD_EN
    assign rs_busy_o      = lk_hit_s & ~lk_done_s;
    assign rs_fwd_valid_o = lk_hit_s & lk_done_s;
    assign rs_fwd_data_o  = {rs_fwd_valid_o[1] ? lk_data_s[1] : {DATA_W{1'b0}},
                             rs_fwd_valid_o[0] ? lk_data_s[0] : {DATA_W{1'b0}}};
`else
    assign rs_busy_o      = lk_hit_s;
    assign rs_fwd_valid_o = 2'b00;
    assign rs_fwd_data_o  = '0;
`endif

    // Next state: flush overrides writeback, commit and issue of the same cycle.
    always_comb begin
        valid_d   = valid_q;
        done_d    = done_q;
        fpr_d     = fpr_q;
        ex_d      = ex_q;
        rd_d      = rd_q;
        data_d    = data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        wb_take_s = 1'b0;
        if (flush_i) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Descending port order lets the lowest matching port write last.
            for (int e = 0; e < NR_ENTRIES; e++) begin
                for (int k = NR_WB_PORTS - 1; k >= 0; k--) begin
                    wb_take_s = wb_valid_i[k] && (wb_trans_id_i[k] == TID_W'(e)) && valid_q[e] && !done_q[e];
                    done_d[e] = done_d[e] | wb_take_s;
                    data_d[e] = wb_take_s ? wb_data_i[k] : data_d[e];
                    ex_d[e]   = wb_take_s ? wb_ex_i[k]   : ex_d[e];
                end
            end
            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                valid_d[cidx_s[i]] = valid_d[cidx_s[i]] & ~ack_s[i];
                done_d[cidx_s[i]]  = done_d[cidx_s[i]]  & ~ack_s[i];
            end
            if (issue_hs_s) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                rd_d[tail_q]    = issue_rd_i;
                fpr_d[tail_q]   = issue_fpr_i;
                tail_d          = tail_q + TID_W'(1'b1);
            end else begin
                tail_d          = tail_q;
            end
            head_d  = head_q + n_ack_s[TID_W-1:0];
            count_d = count_q + (TID_W+1)'(issue_hs_s) - n_ack_s;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            done_q  <= '0;
            fpr_q   <= '0;
            ex_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int e = 0; e < NR_ENTRIES; e++) begin
                rd_q[e]   <= '0;
                data_q[e] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            fpr_q   <= fpr_d;
            ex_q    <= ex_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

endmodule
